// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, field
// positions, write masks and the helpers used by the read bypass.
// Optional feature macro: CSR_MCOUNTINHIBIT_EN (adds mcountinhibit at 0x320).
package csr_file_pkg;

   typedef enum logic [11:0] {
      CSR_MSTATUS       = 12'h300,
      CSR_MISA          = 12'h301,
      CSR_MIE           = 12'h304,
      CSR_MTVEC         = 12'h305,
      CSR_MCOUNTINHIBIT = 12'h320,
      CSR_MSCRATCH      = 12'h340,
      CSR_MEPC          = 12'h341,
      CSR_MCAUSE        = 12'h342,
      CSR_MTVAL         = 12'h343,
      CSR_MIP           = 12'h344,
      CSR_MCYCLE        = 12'hB00,
      CSR_MINSTRET      = 12'hB02,
      CSR_MCYCLEH       = 12'hB80,
      CSR_MINSTRETH     = 12'hB82,
      CSR_CYCLE         = 12'hC00,
      CSR_INSTRET       = 12'hC02,
      CSR_CYCLEH        = 12'hC80,
      CSR_INSTRETH      = 12'hC82,
      CSR_MHARTID       = 12'hF14
   } csr_addr_e;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

   localparam logic [31:0] MSTATUS_RESET       = 32'h0000_1800;
   localparam logic [31:0] MSTATUS_WMASK       = 32'h0000_0088;
   localparam logic [31:0] MIE_WMASK           = 32'h0000_0888;
   localparam logic [31:0] MTVEC_WMASK         = 32'hFFFF_FFFD;
   localparam logic [31:0] MEPC_WMASK          = 32'hFFFF_FFFC;
   localparam logic [31:0] MCOUNTINHIBIT_WMASK = 32'h0000_0005;
   localparam logic [31:0] MISA_VALUE          = 32'h4000_0100;

   // True for addresses that accept software writes
   function automatic logic csr_writable(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MTVAL, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH:
            return 1'b1;
`ifdef CSR_MCOUNTINHIBIT_EN
         CSR_MCOUNTINHIBIT:
            return 1'b1;
`endif
         default:
            return 1'b0;
      endcase
   endfunction

   // Value a register would read back after a software write of wdata
   function automatic logic [31:0] csr_wmask(input logic [11:0] addr, input logic [31:0] wdata);
      case (addr)
         CSR_MSTATUS:       return (wdata & MSTATUS_WMASK) | MSTATUS_RESET;
         CSR_MIE:           return wdata & MIE_WMASK;
         CSR_MTVEC:         return wdata & MTVEC_WMASK;
         CSR_MEPC:          return wdata & MEPC_WMASK;
         CSR_MCOUNTINHIBIT: return wdata & MCOUNTINHIBIT_WMASK;
         default:           return wdata;
      endcase
   endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access port between the pipeline (write-back write, execute read) and
// the CSR file. The master side is the pipeline, the slave is the CSR file.
interface csr_file_if;
   logic        csr_we_i;
   logic [31:0] csr_waddr_i;
   logic [31:0] csr_wdata_i;
   logic        instret_incr_i;
   logic [31:0] csr_raddr_i;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;

   modport master (
      output csr_we_i, csr_waddr_i, csr_wdata_i, instret_incr_i, csr_raddr_i,
      input  csr_rdata_o, csr_illegal_o
   );

   modport slave (
      input  csr_we_i, csr_waddr_i, csr_wdata_i, instret_incr_i, csr_raddr_i,
      output csr_rdata_o, csr_illegal_o
   );
endinterface

// File: rtl/csr_file_counter64.sv
// 64-bit counter built from two software-visible 32-bit halves. A low-word
// write replaces the low half and suppresses that cycle's increment; a
// high-word write replaces the high half while the low half still counts
// and any carry out of it is lost.
module csr_counter64 (
   input  logic        clk_i,
   input  logic        n_rst_i,
   input  logic        incr_i,
   input  logic        we_lo_i,
   input  logic        we_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] value_o
);

   logic [63:0] value_q;
   logic [63:0] value_d;
   logic [63:0] sum;

   // Next value: plain increment unless a software write overrides a half
   always_comb begin
      sum     = value_q + {63'd0, incr_i};
      value_d = sum;
      if (we_lo_i) begin
         value_d = {value_q[63:32], wdata_i};
      end else if (we_hi_i) begin
         value_d = {wdata_i, sum[31:0]};
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         value_q <= 64'd0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file at the write-back end of the pipeline: trap CSRs,
// cycle/instret counters, latched interrupt-pending bits and the combinational
// read port used by execute.
// Optional feature macro: CSR_MCOUNTINHIBIT_EN (mcountinhibit at 0x320).
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] HART_ID     = 32'h0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            n_rst_i,
   csr_file_if.slave       bus,
   input  logic            trap_i,
   input  logic [31:0]     trap_pc_i,
   input  logic [31:0]     trap_cause_i,
   input  logic [31:0]     trap_tval_i,
   input  logic            mret_i,
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   output logic [31:0]     mtvec_o,
   output logic [31:0]     mepc_o,
   output logic            mstatus_mie_o,
   output logic [31:0]     mie_o,
   output logic [31:0]     mip_o
);

   logic [11:0] waddr;
   logic [11:0] raddr;
   logic [31:0] wdata;
   logic        we;

   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] mip_q, mip_d;
   logic [63:0] mcycle, minstret;
   logic        cycle_incr, instret_incr;
   logic [31:0] rdata;
   logic        illegal;

   assign waddr = bus.csr_waddr_i[11:0];
   assign raddr = bus.csr_raddr_i[11:0];
   assign wdata = bus.csr_wdata_i;
   assign we    = bus.csr_we_i;

`ifdef CSR_MCOUNTINHIBIT_EN
   logic [31:0] mcountinhibit_q, mcountinhibit_d;

   // mcountinhibit register; CY and IR are the only live bits
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         mcountinhibit_q <= 32'd0;
      end else begin
         mcountinhibit_q <= mcountinhibit_d;
      end
   end

   assign mcountinhibit_d = (we && waddr == CSR_MCOUNTINHIBIT) ?
                            (wdata & MCOUNTINHIBIT_WMASK) : mcountinhibit_q;
   assign cycle_incr      = ~mcountinhibit_q[0];
   assign instret_incr    = bus.instret_incr_i & ~mcountinhibit_q[2];
`else
   assign cycle_incr      = 1'b1;
   assign instret_incr    = bus.instret_incr_i;
`endif

   csr_counter64 u_mcycle (
      .clk_i   (clk_i),
      .n_rst_i (n_rst_i),
      .incr_i  (cycle_incr),
      .we_lo_i (we && waddr == CSR_MCYCLE),
      .we_hi_i (we && waddr == CSR_MCYCLEH),
      .wdata_i (wdata),
      .value_o (mcycle)
   );

   csr_counter64 u_minstret (
      .clk_i   (clk_i),
      .n_rst_i (n_rst_i),
      .incr_i  (instret_incr),
      .we_lo_i (we && waddr == CSR_MINSTRET),
      .we_hi_i (we && waddr == CSR_MINSTRETH),
      .wdata_i (wdata),
      .value_o (minstret)
   );

   // Next state of the trap CSRs: trap beats mret beats a software write
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mip_d          = 32'd0;
      mip_d[3]       = irq_sw_i;
      mip_d[7]       = irq_timer_i;
      mip_d[11]      = irq_ext_i;

      if (trap_i) begin
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
         mepc_d         = trap_pc_i & MEPC_WMASK;
         mcause_d       = trap_cause_i;
         mtval_d        = trap_tval_i;
      end else if (mret_i) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (we && waddr == CSR_MSTATUS) begin
         mstatus_mie_d  = wdata[MSTATUS_MIE_BIT];
         mstatus_mpie_d = wdata[MSTATUS_MPIE_BIT];
      end

      if (we) begin
         case (waddr)
            CSR_MIE:      mie_d      = wdata & MIE_WMASK;
            CSR_MTVEC:    mtvec_d    = wdata & MTVEC_WMASK;
            CSR_MSCRATCH: mscratch_d = wdata;
            CSR_MEPC:     if (!trap_i) mepc_d   = wdata & MEPC_WMASK;
            CSR_MCAUSE:   if (!trap_i) mcause_d = wdata;
            CSR_MTVAL:    if (!trap_i) mtval_d  = wdata;
            default:      ;
         endcase
      end
   end

   // Trap CSR and interrupt-pending registers
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= 32'd0;
         mtvec_q        <= MTVEC_RESET;
         mscratch_q     <= 32'd0;
         mepc_q         <= 32'd0;
         mcause_q       <= 32'd0;
         mtval_q        <= 32'd0;
         mip_q          <= 32'd0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mip_q          <= mip_d;
      end
   end

   // Read mux with same-cycle bypass of a pending write to the same CSR
   always_comb begin
      rdata   = 32'd0;
      illegal = 1'b0;
      case (raddr)
         CSR_MSTATUS: begin
            rdata                   = MSTATUS_RESET;
            rdata[MSTATUS_MIE_BIT]  = mstatus_mie_q;
            rdata[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
         end
         CSR_MISA:                   rdata = MISA_VALUE;
         CSR_MIE:                    rdata = mie_q;
         CSR_MTVEC:                  rdata = mtvec_q;
         CSR_MSCRATCH:               rdata = mscratch_q;
         CSR_MEPC:                   rdata = mepc_q;
         CSR_MCAUSE:                 rdata = mcause_q;
         CSR_MTVAL:                  rdata = mtval_q;
         CSR_MIP:                    rdata = mip_q;
         CSR_MCYCLE, CSR_CYCLE:      rdata = mcycle[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:    rdata = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:  rdata = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
         CSR_MHARTID:                rdata = HART_ID;
`ifdef CSR_MCOUNTINHIBIT_EN
         CSR_MCOUNTINHIBIT:          rdata = mcountinhibit_q;
`endif
         default:                    illegal = 1'b1;
      endcase
      if (we && waddr == raddr && csr_writable(waddr)) begin
         rdata = csr_wmask(waddr, wdata);
      end
   end

   assign bus.csr_rdata_o   = rdata;
   assign bus.csr_illegal_o = illegal;
   assign mtvec_o           = mtvec_q;
   assign mepc_o            = mepc_q;
   assign mstatus_mie_o     = mstatus_mie_q;
   assign mie_o             = mie_q;
   assign mip_o             = mip_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural CSR model kept here.
module tb_csr_file;

   localparam logic [31:0] HART  = 32'h0000_0005;
   localparam logic [31:0] MTVR  = 32'h0000_1000;

   logic        clk;
   logic        nRst;
   logic        trap, mret, irqSw, irqTimer, irqExt;
   logic [31:0] trapPc, trapCause, trapTval;
   logic [31:0] mtvecO, mepcO, mieO, mipO;
   logic        mstatusMieO;
   logic        checkEn;
   int          checkCount;
   int          passCount;

   csr_file_if bus ();

   csr_file #(.HART_ID(HART), .MTVEC_RESET(MTVR)) dut (
      .clk_i         (clk),
      .n_rst_i       (nRst),
      .bus           (bus),
      .trap_i        (trap),
      .trap_pc_i     (trapPc),
      .trap_cause_i  (trapCause),
      .trap_tval_i   (trapTval),
      .mret_i        (mret),
      .irq_sw_i      (irqSw),
      .irq_timer_i   (irqTimer),
      .irq_ext_i     (irqExt),
      .mtvec_o       (mtvecO),
      .mepc_o        (mepcO),
      .mstatus_mie_o (mstatusMieO),
      .mie_o         (mieO),
      .mip_o         (mipO)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state: whole CSR values as software sees them
   bit [31:0] mMstatus, mMie, mMtvec, mMscratch, mMepc, mMcause, mMtval, mMip, mMinhibit;
   bit [63:0] mCycle, mInstret;

   function automatic bit isWritable(input bit [11:0] a);
      case (a)
         12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
         12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
`ifdef CSR_MCOUNTINHIBIT_EN
         12'h320: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit [31:0] writtenValue(input bit [11:0] a, input bit [31:0] d);
      case (a)
         12'h300: return 32'h1800 | (d & 32'h88);
         12'h304: return d & 32'h888;
         12'h305: return d & ~32'h2;
         12'h341: return d & ~32'h3;
         12'h320: return d & 32'h5;
         default: return d;
      endcase
   endfunction

   task automatic modelReset();
      mMstatus  = 32'h1800;
      mMie      = 0;
      mMtvec    = MTVR;
      mMscratch = 0;
      mMepc     = 0;
      mMcause   = 0;
      mMtval    = 0;
      mMip      = 0;
      mMinhibit = 0;
      mCycle    = 0;
      mInstret  = 0;
   endtask

   task automatic modelStep();
      bit [11:0] wa;
      bit [31:0] wd;
      bit        we, cycRun, instRun, oldMie, oldMpie;
      wa      = bus.csr_waddr_i[11:0];
      wd      = bus.csr_wdata_i;
      we      = bus.csr_we_i;
      cycRun  = 1'b1;
      instRun = bus.instret_incr_i;
`ifdef CSR_MCOUNTINHIBIT_EN
      if (mMinhibit[0]) cycRun = 1'b0;
      if (mMinhibit[2]) instRun = 1'b0;
`endif
      if (we && wa == 12'hB00) mCycle[31:0] = wd;
      else if (we && wa == 12'hB80) begin
         mCycle[31:0]  = mCycle[31:0] + 32'(cycRun);
         mCycle[63:32] = wd;
      end else mCycle = mCycle + 64'(cycRun);
      if (we && wa == 12'hB02) mInstret[31:0] = wd;
      else if (we && wa == 12'hB82) begin
         mInstret[31:0]  = mInstret[31:0] + 32'(instRun);
         mInstret[63:32] = wd;
      end else mInstret = mInstret + 64'(instRun);

      oldMie  = mMstatus[3];
      oldMpie = mMstatus[7];
      if (trap) begin
         mMstatus[7] = oldMie;
         mMstatus[3] = 1'b0;
         mMepc       = {trapPc[31:2], 2'b00};
         mMcause     = trapCause;
         mMtval      = trapTval;
      end else if (mret) begin
         mMstatus[3] = oldMpie;
         mMstatus[7] = 1'b1;
      end
      if (we) begin
         case (wa)
            12'h300: if (!trap && !mret) mMstatus = writtenValue(wa, wd);
            12'h304: mMie = writtenValue(wa, wd);
            12'h305: mMtvec = writtenValue(wa, wd);
            12'h340: mMscratch = wd;
            12'h341: if (!trap) mMepc = writtenValue(wa, wd);
            12'h342: if (!trap) mMcause = wd;
            12'h343: if (!trap) mMtval = wd;
`ifdef CSR_MCOUNTINHIBIT_EN
            12'h320: mMinhibit = writtenValue(wa, wd);
`endif
            default: ;
         endcase
      end
      mMip = {20'd0, irqExt, 3'd0, irqTimer, 3'd0, irqSw, 3'd0};
   endtask

   // Model read port for the current inputs
   task automatic modelRead(output bit [31:0] rd, output bit ill);
      bit [11:0] ra;
      ra  = bus.csr_raddr_i[11:0];
      rd  = 0;
      ill = 0;
      case (ra)
         12'h300: rd = mMstatus;
         12'h301: rd = 32'h4000_0100;
         12'h304: rd = mMie;
         12'h305: rd = mMtvec;
         12'h340: rd = mMscratch;
         12'h341: rd = mMepc;
         12'h342: rd = mMcause;
         12'h343: rd = mMtval;
         12'h344: rd = mMip;
         12'hB00, 12'hC00: rd = mCycle[31:0];
         12'hB80, 12'hC80: rd = mCycle[63:32];
         12'hB02, 12'hC02: rd = mInstret[31:0];
         12'hB82, 12'hC82: rd = mInstret[63:32];
         12'hF14: rd = HART;
`ifdef CSR_MCOUNTINHIBIT_EN
         12'h320: rd = mMinhibit;
`endif
         default: ill = 1;
      endcase
      if (bus.csr_we_i && bus.csr_waddr_i[11:0] == ra && isWritable(ra))
         rd = writtenValue(ra, bus.csr_wdata_i);
   endtask

   // Model advances on the same edges as the design
   always @(posedge clk or negedge nRst) begin
      if (!nRst) modelReset();
      else modelStep();
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      else
         passCount++;
   endtask

   // Every-cycle comparison of all outputs against the model, mid-cycle
   always @(negedge clk) begin
      bit [31:0] expRd;
      bit        expIll;
      if (checkEn) begin
         modelRead(expRd, expIll);
         checkOutput("rdata",       bus.csr_rdata_o, expRd);
         checkOutput("illegal",     {31'd0, bus.csr_illegal_o}, {31'd0, expIll});
         checkOutput("mtvec_o",     mtvecO, mMtvec);
         checkOutput("mepc_o",      mepcO, mMepc);
         checkOutput("mstatus_mie", {31'd0, mstatusMieO}, {31'd0, mMstatus[3]});
         checkOutput("mie_o",       mieO, mMie);
         checkOutput("mip_o",       mipO, mMip);
      end
   end

   task automatic idleInputs();
      bus.csr_we_i       = 0;
      bus.csr_waddr_i    = 0;
      bus.csr_wdata_i    = 0;
      bus.instret_incr_i = 0;
      bus.csr_raddr_i    = 0;
      trap = 0; trapPc = 0; trapCause = 0; trapTval = 0;
      mret = 0; irqSw = 0; irqTimer = 0; irqExt = 0;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      idleInputs();
   endtask

   task automatic writeCsr(input bit [11:0] a, input bit [31:0] d);
      bus.csr_we_i    = 1;
      bus.csr_waddr_i = {20'd0, a};
      bus.csr_wdata_i = d;
   endtask

   bit [11:0] addrList [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340,
                                12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02,
                                12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
                                12'hF14, 12'h7C0, 12'h123};

   // Watchdog so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      checkCount = 0;
      passCount  = 0;
      checkEn    = 0;
      nRst       = 0;
      idleInputs();
      repeat (3) @(posedge clk);
      #1 nRst = 1;
      checkEn = 1;

      bus.csr_raddr_i = 32'h300;
      @(negedge clk);
      checkOutput("rst_mstatus", bus.csr_rdata_o, 32'h0000_1800);
      checkOutput("rst_mepc", mepcO, 32'h0);
      applyStimulus();
      bus.csr_raddr_i = 32'h305;
      @(negedge clk);
      checkOutput("rst_mtvec", bus.csr_rdata_o, 32'h0000_1000);
      applyStimulus();
      bus.csr_raddr_i = 32'hF14;
      @(negedge clk);
      checkOutput("rst_mhartid", bus.csr_rdata_o, 32'h0000_0005);
      applyStimulus();
      bus.csr_raddr_i = 32'h301;
      @(negedge clk);
      checkOutput("rst_misa", bus.csr_rdata_o, 32'h4000_0100);
      applyStimulus();
      bus.csr_raddr_i = 32'h7C0;
      @(negedge clk);
      checkOutput("unimpl_rdata", bus.csr_rdata_o, 32'h0);
      checkOutput("unimpl_illegal", {31'd0, bus.csr_illegal_o}, 32'h1);

      applyStimulus();
      writeCsr(12'h304, 32'hFFFF_FFFF);
      bus.csr_raddr_i = 32'h304;
      @(negedge clk);
      checkOutput("mie_bypass", bus.csr_rdata_o, 32'h0000_0888);
      applyStimulus();
      bus.csr_raddr_i = 32'h304;
      @(negedge clk);
      checkOutput("mie_read", bus.csr_rdata_o, 32'h0000_0888);
      checkOutput("model_mie", mMie, 32'h0000_0888);

      applyStimulus();
      writeCsr(12'hB00, 32'hFFFF_FFFE);
      applyStimulus();
      writeCsr(12'hB80, 32'h0);
      applyStimulus();
      bus.csr_raddr_i = 32'hB00;
      @(negedge clk);
      checkOutput("mcycle_lo_nocarry", bus.csr_rdata_o, 32'hFFFF_FFFF);
      checkOutput("model_mcycle", mCycle[31:0], 32'hFFFF_FFFF);
      applyStimulus();
      bus.csr_raddr_i = 32'hB80;
      @(negedge clk);
      checkOutput("mcycle_hi_carry", bus.csr_rdata_o, 32'h1);

      applyStimulus();
      writeCsr(12'hB02, 32'h0);
      applyStimulus();
      writeCsr(12'hB82, 32'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         bus.instret_incr_i = 1;
      end
      applyStimulus();
      bus.csr_raddr_i = 32'hB02;
      @(negedge clk);
      checkOutput("minstret_plus5", bus.csr_rdata_o, 32'd5);
      applyStimulus();
      writeCsr(12'hB02, 32'd100);
      bus.instret_incr_i = 1;
      applyStimulus();
      bus.csr_raddr_i = 32'hC02;
      @(negedge clk);
      checkOutput("minstret_write_wins", bus.csr_rdata_o, 32'd100);

      applyStimulus();
      writeCsr(12'h300, 32'h8);
      applyStimulus();
      trap = 1; trapPc = 32'h8000_0102; trapCause = 32'h8000_0007; trapTval = 32'hDEAD;
      bus.csr_raddr_i = 32'h300;
      @(negedge clk);
      checkOutput("mstatus_mie_set", bus.csr_rdata_o, 32'h0000_1808);
      applyStimulus();
      bus.csr_raddr_i = 32'h342;
      @(negedge clk);
      checkOutput("trap_mcause", bus.csr_rdata_o, 32'h8000_0007);
      checkOutput("trap_mepc", mepcO, 32'h8000_0100);
      checkOutput("trap_mie", {31'd0, mstatusMieO}, 32'h0);
      applyStimulus();
      bus.csr_raddr_i = 32'h300;
      mret = 1;
      @(negedge clk);
      checkOutput("trap_mstatus", bus.csr_rdata_o, 32'h0000_1880);
      applyStimulus();
      bus.csr_raddr_i = 32'h300;
      @(negedge clk);
      checkOutput("mret_mstatus", bus.csr_rdata_o, 32'h0000_1888);
      checkOutput("mret_mie", {31'd0, mstatusMieO}, 32'h1);

      applyStimulus();
      trap = 1; trapPc = 32'h0000_0047;
      writeCsr(12'h341, 32'h1234);
      bus.csr_raddr_i = 32'h340;
      applyStimulus();
      bus.csr_raddr_i = 32'h341;
      @(negedge clk);
      checkOutput("trap_beats_write", bus.csr_rdata_o, 32'h0000_0044);

      applyStimulus();
      irqTimer = 1;
      @(negedge clk);
      checkOutput("mip_latency", mipO, 32'h0);
      applyStimulus();
      @(negedge clk);
      checkOutput("mip_timer", mipO, 32'h0000_0080);
      applyStimulus();
      @(negedge clk);
      checkOutput("mip_clear", mipO, 32'h0);

      // Randomized traffic, with one asynchronous reset mid-run
      for (int i = 0; i < 3000; i++) begin
         applyStimulus();
         bus.csr_we_i    = ($urandom_range(0, 1) == 1);
         bus.csr_waddr_i = {(($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0),
                            addrList[$urandom_range(0, 20)]};
         bus.csr_wdata_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
         if ($urandom_range(0, 3) == 0)
            bus.csr_raddr_i = bus.csr_waddr_i;
         else
            bus.csr_raddr_i = {(($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0),
                               addrList[$urandom_range(0, 20)]};
         bus.instret_incr_i = ($urandom_range(0, 1) == 1);
         trap      = ($urandom_range(0, 11) == 0);
         trapPc    = $urandom;
         trapCause = $urandom;
         trapTval  = $urandom;
         mret      = ($urandom_range(0, 11) == 0);
         irqSw     = ($urandom_range(0, 1) == 1);
         irqTimer  = ($urandom_range(0, 1) == 1);
         irqExt    = ($urandom_range(0, 1) == 1);
         if (i == 1500) begin
            #2 nRst = 0;
            @(posedge clk);
            #2 nRst = 1;
         end
      end

      applyStimulus();
      @(negedge clk);
      checkEn = 0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
